// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: fetch port,
// load/store port, memory macro port and pipeline busy flag.
interface unified_mem_arbiter_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 12
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [N-1:0]      if_rdata;
   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [N-1:0]      d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [N-1:0]      d_rdata;
   logic              d_err;
   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-3:0] mem_addr;
   logic [N-1:0]      mem_wdata;
   logic [N-1:0]      mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_size, d_addr, d_wdata,
      input  mem_rdata,
      output if_gnt, if_valid, if_rdata,
      output d_gnt, d_valid, d_rdata, d_err,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_size, d_addr, d_wdata,
      output mem_rdata,
      input  if_gnt, if_valid, if_rdata,
      input  d_gnt, d_valid, d_rdata, d_err,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Fetch / load-store arbiter for one single-port unified memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking (default: data wins).
module unified_mem_arbiter #(
   parameter int N       = 32,
   parameter int ADDR_W  = 12,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   unified_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

   state_t            state;
   state_t            nxt;
   logic              sel_d;
   logic              we;
   logic              err;
   logic [1:0]        size;
   logic [1:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic [N-1:0]      wdata;
   logic [N-1:0]      if_rdata;
   logic [N-1:0]      d_rdata;
   logic              dec;
   logic              any;
   logic              pick_d;
   logic              mis_d;
   logic              mis_i;
   logic              last;
   logic              acc;
   logic [3:0]        be;
   logic [N-1:0]      rep;

   assign dec   = (state == IDLE) || (state == RESP);
   assign any   = bus.if_req | bus.d_req;
   assign mis_i = |bus.if_addr[1:0];
   assign last  = (cnt == LAST);
   assign acc   = (state == ISSUE) & ~err;

`ifdef MEM_ARB_RR_EN
   logic last_gnt;

   // last_gnt=1 means data won the previous decision
   assign pick_d = bus.d_req & (~bus.if_req | ~last_gnt);

   always_ff @(posedge clk) begin
      if (rst)
         last_gnt <= 1'b0;
      else if (dec && any)
         last_gnt <= pick_d;
   end
`else
   assign pick_d = bus.d_req;
`endif

   always_comb begin
      mis_d = 1'b0;
      case (bus.d_size)
         2'b00:   mis_d = 1'b0;
         2'b01:   mis_d = bus.d_addr[0];
         default: mis_d = |bus.d_addr[1:0];
      endcase
   end

   always_comb begin
      be  = 4'b1111;
      rep = wdata;
      if (we) begin
         case (size)
            2'b00: begin
               be  = 4'b0001 << addr[1:0];
               rep = {4{wdata[7:0]}};
            end
            2'b01: begin
               be  = addr[1] ? 4'b1100 : 4'b0011;
               rep = {2{wdata[15:0]}};
            end
            default: begin
               be  = 4'b1111;
               rep = wdata;
            end
         endcase
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  nxt = any ? ISSUE : IDLE;
         ISSUE: nxt = (err || we) ? RESP : WAIT;
         WAIT:  nxt = last ? RESP : WAIT;
         RESP:  nxt = any ? ISSUE : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel_d    <= 1'b0;
         we       <= 1'b0;
         err      <= 1'b0;
         size     <= 2'b00;
         cnt      <= 2'b00;
         addr     <= '0;
         wdata    <= '0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         state <= nxt;
         if (dec && any) begin
            sel_d <= pick_d;
            if (pick_d) begin
               addr  <= bus.d_addr;
               size  <= bus.d_size;
               we    <= bus.d_we;
               wdata <= bus.d_wdata;
               err   <= mis_d;
            end else begin
               addr <= bus.if_addr;
               size <= 2'b10;
               we   <= 1'b0;
               err  <= mis_i;
            end
         end
         if (state == ISSUE)
            cnt <= 2'b00;
         else if (state == WAIT)
            cnt <= cnt + 2'b01;
         if (state == WAIT && last) begin
            if (sel_d)
               d_rdata <= bus.mem_rdata;
            else
               if_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.if_gnt    = (state == ISSUE) & ~sel_d;
   assign bus.d_gnt     = (state == ISSUE) & sel_d;
   assign bus.if_valid  = (state == RESP) & ~sel_d;
   assign bus.d_valid   = (state == RESP) & sel_d;
   assign bus.d_err     = (state == RESP) & sel_d & err;
   assign bus.if_rdata  = if_rdata;
   assign bus.d_rdata   = d_rdata;
   assign bus.mem_en    = acc;
   assign bus.mem_we    = acc & we;
   assign bus.mem_be    = acc ? be : 4'b0000;
   assign bus.mem_addr  = addr[ADDR_W-1:2];
   assign bus.mem_wdata = rep;
   assign bus.busy      = (state != IDLE);
endmodule
